alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  signed operands.
REQ-007 req0_op / req1_op  input  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
REQ-008 rsp_valid  output  1  response register holds a result.
REQ-009 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-010 rsp_id  output  1  requester index owning the response.
REQ-011 rsp_result  output  32  registered ALU result.
REQ-012 rsp_v, rsp_n, rsp_zero  output  1 each  registered ALU flags.

Function
REQ-013 The block SHALL instantiate the team's existing combinational alu block once and share it between the two requesters.
REQ-014 ALU semantics SHALL be unchanged: V/N/Zero computed only for ADD/SUB, all three 0 for other ops; shifts use the full B value.
REQ-015 State machine SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 Issue is possible in a cycle when state is EMPTY, or FULL with rsp_ready=1 (drain and refill same cycle, zero bubble).
REQ-017 In an issue-possible cycle with at least one reqN_valid, exactly one winner SHALL be chosen and only its reqN_ready asserted; the loser's ready stays 0.
REQ-018 reqN_ready SHALL never be asserted without reqN_valid, and never when issue is not possible.
REQ-019 Arbitration (default): round-robin; a 1-bit last-grant pointer; on contention the requester not last granted wins; pointer updates only on an actual grant.
REQ-020 Accepted operation in cycle N SHALL appear on rsp_* with rsp_valid=1 in cycle N+1 (latency 1); rsp_id = winner index.
REQ-021 FULL with rsp_ready=0: rsp_* SHALL hold stable, both reqN_ready=0.
REQ-022 FULL with rsp_ready=1 and no valid request: next state EMPTY, rsp_valid=0.
REQ-023 reqN_ready SHALL be combinational from valids, state, rsp_ready and pointer; requesters hold operands stable while valid and not ready.
REQ-024 Requests are never dropped or reordered per requester; a pending request remains until its ready.
REQ-025 Under round-robin, a continuously valid requester SHALL be granted within 2 issue-possible cycles.

Reset
REQ-026 While reset=1: state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_v=rsp_n=rsp_zero=0, pointer=1 (requester 0 wins first contention), both reqN_ready=0.
REQ-027 Reset during FULL SHALL discard the held response; no response for it is ever presented.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention (pointer unused); when undefined, round-robin per REQ-019.
REQ-029 With ALU_ARB_FIXED_PRIO_EN defined, REQ-025 is waived for requester 1; all other requirements unchanged.

Verification
REQ-030 After reset, req0 ADD a=5,b=7, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, result=12, V=N=Zero=0.
REQ-031 req1 SUB a=3,b=3 -> result=0, Zero=1, N=0, V=0, rsp_id=1; req0 ADD 0x7FFFFFFF+1 -> result=0x80000000, V=1, N=1.
REQ-032 Both valid continuously from reset, rsp_ready=1 -> grants 0,1,0,1 on consecutive cycles, rsp_valid continuously 1 (with macro: grants 0,0,0,0).
REQ-033 rsp_ready=0 for 3 cycles while FULL, both valid -> rsp_* stable, both ready=0; on rsp_ready=1 next grant issues same cycle.
REQ-034 Assert reset in FULL state -> next cycle rsp_valid=0, all rsp_* outputs 0; after release req0 wins first contention.
REQ-035 req0 AND 0xF0F0F0F0 & 0xFF00FF00 -> result=0xF000F000, flags all 0; SLT a=-1,b=1 -> result=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU, 1-deep response register; ALU_ARB_FIXED_PRIO_EN selects fixed priority
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        v,
    output logic        n,
    output logic        zero
);
    always_comb begin
        result = '0;
        v      = 1'b0;
        n      = 1'b0;
        zero   = 1'b0;
        case (op)
            3'b000: begin
                result = a + b;
                v      = (a[31] == b[31]) && (result[31] != a[31]);
                n      = result[31];
                zero   = (result == 32'd0);
            end
            3'b001: begin
                result = a - b;
                v      = (a[31] != b[31]) && (result[31] != a[31]);
                n      = result[31];
                zero   = (result == 32'd0);
            end
            3'b010: result = a & b;
            3'b011: result = a | b;
            3'b100: result = a ^ b;
            // Shift amount is the whole of b: anything of 32 or more clears the result.
            3'b101: result = (|b[31:5]) ? 32'd0 : (a << b[4:0]);
            3'b110: result = (|b[31:5]) ? 32'd0 : (a >> b[4:0]);
            default: result = {31'd0, ($signed(a) < $signed(b))};
        endcase
    end
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_v,
    output logic        rsp_n,
    output logic        rsp_zero
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_nxt;
    logic        issue_ok, win0, grant0, grant1;
    logic [31:0] opa, opb, alu_result;
    logic [2:0]  opc;
    logic        alu_v, alu_n, alu_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win0 = 1'b1;
`else
    // last_grant=1 means requester 1 was served last, so requester 0 wins the next tie.
    logic last_grant;
    assign win0 = last_grant;
`endif

    always_comb begin
        state_nxt = state;
        issue_ok  = (state == EMPTY) || rsp_ready;
        grant0    = !reset && issue_ok && req0_valid && (!req1_valid || win0);
        grant1    = !reset && issue_ok && req1_valid && !grant0;
        if (grant0 || grant1)
            state_nxt = FULL;
        else if (state == FULL && rsp_ready)
            state_nxt = EMPTY;
        opa = grant1 ? req1_a  : req0_a;
        opb = grant1 ? req1_b  : req0_b;
        opc = grant1 ? req1_op : req0_op;
    end

    alu u_alu (
        .a      (opa),
        .b      (opb),
        .op     (opc),
        .result (alu_result),
        .v      (alu_v),
        .n      (alu_n),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_v      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                rsp_id     <= grant1;
                rsp_result <= alu_result;
                rsp_v      <= alu_v;
                rsp_n      <= alu_n;
                rsp_zero   <= alu_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant <= grant1;
`endif
            end
        end
    end

    assign rsp_valid  = (state == FULL);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - vector table, directed sequences and randomized model comparison for alu_arbiter
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_v, rsp_n, rsp_zero;
    logic [31:0] rsp_result;

    int n_vec = 0;
    int n_bad = 0;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_v(rsp_v), .rsp_n(rsp_n), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic        v, n, z;
    } vec_t;

    vec_t tbl[12];

    // Model state for the random phase
    bit          m_full;
    int          m_last;
    logic        m_id, m_v, m_n, m_z;
    logic [31:0] m_res;
    bit          pv[2];
    logic [2:0]  pop[2];
    logic [31:0] pa[2], pb[2];
    int          g[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic v, output logic n, output logic z);
        longint sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        v = 1'b0; n = 1'b0; z = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? sa + sb : sa - sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                n = r[31];
                z = (r == 32'd0);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (b >= 32) ? 32'd0 : a << b;
            3'd6: r = (b >= 32) ? 32'd0 : a >> b;
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1'b1, 3'd0, 32'd1, 32'd1);
        drive(1, 1'b1, 3'd0, 32'd2, 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_flags", {rsp_v, rsp_n, rsp_zero}, 0);
        reset = 1'b0;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd1, 32'd3,         32'd3,         32'd0,         1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd7, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd5, 32'd1,         32'd4,         32'd16,        1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd6, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd5, 32'd1,         32'd32,        32'd0,         1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd3, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
        if (FIXED) g = '{0, 0, 0, 0};
        else       g = '{0, 1, 0, 1};

        reset = 1'b1;
        rsp_ready = 1'b0;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        do_reset();

        // Single-requester ALU vectors, consumer always ready
        for (int k = 0; k < 12; k++) begin
            drive(0, tbl[k].id == 1'b0, tbl[k].op, tbl[k].a, tbl[k].b);
            drive(1, tbl[k].id == 1'b1, tbl[k].op, tbl[k].a, tbl[k].b);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready0", k), req0_ready, tbl[k].id == 1'b0);
            chk($sformatf("tbl%0d_ready1", k), req1_ready, tbl[k].id == 1'b1);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", k), rsp_valid, 1);
            chk($sformatf("tbl%0d_id", k), rsp_id, tbl[k].id);
            chk($sformatf("tbl%0d_result", k), rsp_result, tbl[k].res);
            chk($sformatf("tbl%0d_flags", k), {rsp_v, rsp_n, rsp_zero}, {tbl[k].v, tbl[k].n, tbl[k].z});
        end

        // Both requesters continuously valid from reset
        do_reset();
        drive(0, 1'b1, 3'd0, 32'd1, 32'd1);
        drive(1, 1'b1, 3'd0, 32'd10, 32'd10);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_ready0", k), req0_ready, g[k] == 0);
            chk($sformatf("rr%0d_ready1", k), req1_ready, g[k] == 1);
            @(posedge clk); #1;
            chk($sformatf("rr%0d_valid", k), rsp_valid, 1);
            chk($sformatf("rr%0d_id", k), rsp_id, g[k]);
            chk($sformatf("rr%0d_result", k), rsp_result, (g[k] == 1) ? 32'd20 : 32'd2);
        end

        // Consumer stalls for three cycles while FULL
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_ready0", k), req0_ready, 0);
            chk($sformatf("stall%0d_ready1", k), req1_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid", k), rsp_valid, 1);
            chk($sformatf("stall%0d_id", k), rsp_id, g[3]);
            chk($sformatf("stall%0d_result", k), rsp_result, (g[3] == 1) ? 32'd20 : 32'd2);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ready0", req0_ready, 1);
        chk("unstall_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("unstall_id", rsp_id, 0);
        chk("unstall_result", rsp_result, 2);

        // Drain with no request, then refill from requester 1
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("drain_ready0", req0_ready, 0);
        chk("drain_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("drain_valid", rsp_valid, 0);
        drive(1, 1'b1, 3'd1, 32'd5, 32'd2);
        @(negedge clk);
        chk("refill_ready1", req1_ready, 1);
        @(posedge clk); #1;
        chk("refill_valid", rsp_valid, 1);
        chk("refill_result", rsp_result, 3);

        // Reset while FULL discards the response; requester 0 wins afterwards
        rsp_ready = 1'b0;
        do_reset();
        drive(0, 1'b1, 3'd0, 32'd4, 32'd4);
        drive(1, 1'b1, 3'd0, 32'd9, 32'd9);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("postreset_ready0", req0_ready, 1);
        chk("postreset_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("postreset_result", rsp_result, 8);

        // Randomized traffic against the reference model
        do_reset();
        m_full = 1'b0;
        m_last = 1;
        pv = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int  w;
            bit  rr, issue;
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 9) < 6) begin
                    pv[i]  = 1'b1;
                    pop[i] = 3'($urandom_range(0, 7));
                    pa[i]  = rnd_val();
                    pb[i]  = rnd_val();
                end
                drive(i, pv[i], pop[i], pa[i], pb[i]);
            end
            rr = ($urandom_range(0, 3) != 0);
            rsp_ready = rr;
            issue = !m_full || rr;
            if (!issue)               w = -1;
            else if (pv[0] && pv[1])  w = FIXED ? 0 : ((m_last == 1) ? 0 : 1);
            else if (pv[0])           w = 0;
            else if (pv[1])           w = 1;
            else                      w = -1;
            @(negedge clk);
            chk("rnd_ready0", req0_ready, w == 0);
            chk("rnd_ready1", req1_ready, w == 1);
            @(posedge clk);
            if (w >= 0) begin
                alu_ref(pop[w], pa[w], pb[w], m_res, m_v, m_n, m_z);
                m_id   = (w == 1);
                m_full = 1'b1;
                m_last = w;
                pv[w]  = 1'b0;
            end else if (m_full && rr) begin
                m_full = 1'b0;
            end
            #1;
            chk("rnd_valid", rsp_valid, m_full);
            if (m_full) begin
                chk("rnd_id", rsp_id, m_id);
                chk("rnd_result", rsp_result, m_res);
                chk("rnd_flags", {rsp_v, rsp_n, rsp_zero}, {m_v, m_n, m_z});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
